// File: rtl/pipe_stage_chain_if.sv
// Handshake and per-slot control bundle for the elastic pipeline chain.
// master drives the chain, slave is the chain itself.
interface pipe_stage_chain_if #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 5
);
  localparam int CW = $clog2(STAGES + 1);

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WIDTH-1:0]        in_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [WIDTH-1:0]        out_data_o;
  logic [STAGES-1:0]       stall_i;
  logic [STAGES-1:0]       kill_i;
  logic [STAGES-1:0]       stage_valid_o;
  logic [STAGES*WIDTH-1:0] stage_data_o;
  logic [CW-1:0]           occupancy_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    output stall_i, kill_i,
    input  in_ready_o, out_valid_o, out_data_o,
    input  stage_valid_o, stage_data_o, occupancy_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    input  stall_i, kill_i,
    output in_ready_o, out_valid_o, out_data_o,
    output stage_valid_o, stage_data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline backbone: STAGES slots with per-slot stall/kill,
// valid/ready at both ends, bubbles compress below a stalled slot.
module pipe_stage_chain #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 5
) (
  input logic                clk_i,
  input logic                rst_i,
  pipe_stage_chain_if.slave  bus
);
  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  logic [STAGES-1:0] go;
  logic [STAGES-1:0] vac;
  logic [STAGES-1:0] xfer;
  logic [WIDTH-1:0]  din [STAGES];

  // Accept chain, oldest to youngest: a slot may move only if the
  // slot above is (or becomes) free this cycle.
  always_comb begin
    logic acc;
    go  = '0;
    vac = '0;
    acc = bus.out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go[k]  = valid_q[k] & ~bus.kill_i[k] & ~bus.stall_i[k] & acc;
      vac[k] = ~valid_q[k] | bus.kill_i[k] | go[k];
      acc    = vac[k];
    end
  end

  // Incoming transfer and payload for each slot.
  always_comb begin
    xfer    = '0;
    xfer[0] = bus.in_valid_i & vac[0];
    din[0]  = bus.in_data_i;
    for (int k = 1; k < STAGES; k++) begin
      xfer[k] = go[k-1];
      din[k]  = data_q[k-1];
    end
  end

  // Slot registers: load on transfer in, clear when vacated, else hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (xfer[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= din[k];
        end else if (vac[k]) begin
          valid_q[k] <= 1'b0;
          data_q[k]  <= '0;
        end
      end
    end
  end

  // Flatten slot payloads for observation.
  always_comb begin
    bus.stage_data_o = '0;
    for (int k = 0; k < STAGES; k++)
      bus.stage_data_o[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign bus.in_ready_o    = vac[0];
  assign bus.out_valid_o   = valid_q[STAGES-1]
                           & ~bus.kill_i[STAGES-1]
                           & ~bus.stall_i[STAGES-1];
  assign bus.out_data_o    = data_q[STAGES-1];
  assign bus.stage_valid_o = valid_q;
  assign bus.occupancy_o   = CW'($countones(valid_q));
endmodule

// File: doc/pipe_stage_chain.md
Name:
pipe_stage_chain

Overview:
- Parametrised elastic pipeline backbone for the next-generation pipelined CPU. It replaces the fixed chain of flush/write pipeline registers with one configurable block.
- Holds STAGES slots of WIDTH-bit payload, each with its own valid bit.
- Per-slot stall and kill inputs let the hazard unit and branch resolution freeze or squash individual stages.
- valid/ready handshakes at both ends allow fetch and writeback to back-pressure.

Parameters:
- WIDTH, 64, payload bits per stage.
- STAGES, 5, number of pipeline slots (>=2); slot 0 is the youngest (input side), slot STAGES-1 the oldest.
- CW, $clog2(STAGES+1), occupancy width (derived, not overridable).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- in_valid_i  in  1  upstream offers in_data_i.
- in_ready_o  out  1  slot 0 accepts this cycle.
- in_data_i  in  WIDTH  payload entering slot 0.
- out_valid_o  out  1  slot STAGES-1 offers out_data_o.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  WIDTH  payload of slot STAGES-1.
- stall_i  in  STAGES  bit k holds slot k in place.
- kill_i  in  STAGES  bit k squashes the entry currently in slot k.
- stage_valid_o  out  STAGES  valid bit of every slot.
- stage_data_o  out  STAGES*WIDTH  slot k payload at bits [k*WIDTH +: WIDTH].
- occupancy_o  out  CW  number of valid slots.

Behaviour:
- Reset (async, rst_i=1): all valid bits 0, all slot data 0. Outputs stay at those values while rst_i=1: out_valid_o=0, occupancy_o=0. in_ready_o is 1 as soon as rst_i deasserts.
- Reset mid-operation discards all entries. No handshake completes in a cycle whose edge sees rst_i=1.
- Per-slot terms (combinational, evaluated oldest to youngest):
  - acc[STAGES] = out_ready_i.
  - go[k] = valid[k] & ~kill_i[k] & ~stall_i[k] & acc[k+1].
  - vac[k] = ~valid[k] | kill_i[k] | go[k].
  - acc[k] = vac[k].
  - in_ready_o = acc[0].
- Transfer into slot k (k>0) occurs when go[k-1]. Transfer into slot 0 occurs when in_valid_i & acc[0].
- Next state of slot k:
  - Transfer in: valid<=1, data<=incoming.
  - Else if vac[k]: valid<=0, data<=0.
  - Else: hold.
- out_valid_o = valid[STAGES-1] & ~kill_i[STAGES-1] & ~stall_i[STAGES-1]. out_data_o = data[STAGES-1].
- Output transfer occurs when out_valid_o & out_ready_i. The entry then leaves slot STAGES-1.
- Kill semantics:
  - Kill applies to the current occupant only. A killed entry is never forwarded.
  - Its slot is free in the same cycle, so an entry arriving from the slot below is stored normally.
  - kill_i on an empty slot has no effect.
- Kill overrides stall on the same slot.
- Stall on slot k freezes k. Back-pressure propagates combinationally to younger slots only where they are full. Bubbles below a stall still compress (younger entries advance into empty slots).
- Branch squash: the controller asserts kill_i for slots 0..j-1. The same-cycle in_valid_i entry is still accepted into slot 0 if in_ready_o=1; the upstream gates it if it is wrong-path.
- Throughput: 1 entry/cycle with no stalls or kills. Latency from input to output is STAGES cycles when the pipe is flowing.
- occupancy_o = combinational popcount of the valid register bits, range 0..STAGES.
- No combinational path from in_valid_i to in_ready_o. out_ready_i to in_ready_o is combinational through the acc chain (intentional, matches single-cycle stall response).

Test Plan:
- Reset, then streaming (STAGES=5, WIDTH=8): drive 0x01..0x0A on consecutive cycles, out_ready_i=1 -> 0x01 appears on out_data_o on the 5th edge after acceptance, one value per cycle, occupancy_o=5 in steady state.
- Back-pressure: fill the pipe, drop out_ready_i for 3 cycles -> in_ready_o=0, slots hold, no loss or duplication. Release -> resumes in order.
- Stall with bubble compression: slots {4:A, 2:B, 0:C}, stall_i[4]=1 for 2 cycles -> A holds, B and C advance to give {4:A, 3:B, 2:C}, in_ready_o=1.
- Branch kill: full pipe 0x11..0x15, kill_i=5'b00111 with in_valid_i=1, in_data_i=0x20 -> next cycle slots 0..2 hold {0x20, 0, 0} with valid=001 in those slots, occupancy_o=3. Only 0x15 and 0x14 are ever output.
- Kill vs stall plus empty kill: kill_i[3]=stall_i[3]=1 on a valid slot -> entry dropped, slot refilled from slot 2. kill_i on an empty slot -> no change.
- Async reset mid-stream: assert rst_i between edges with occupancy 4 -> stage_valid_o=0 and occupancy_o=0 immediately. After release, the first accepted input exits after exactly STAGES cycles.
